// File: rtl/meikyuu_room_ctrl.sv
// Room sequencer for the meikyuu maze: start/restart, map tile lookup, room fades and exits.
// Build macro MEIKYUU_ROOM_FADE_EN enables the FADE_IN/FADE_OUT states; without it rooms switch instantly.
module meikyuu_room_ctrl #(
    parameter int unsigned FADE_FRAMES = 2,
    parameter int unsigned START_X     = 0,
    parameter int unsigned START_Y     = 0,
    parameter int unsigned GOAL_X      = 7,
    parameter int unsigned GOAL_Y      = 7
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       frame_start,
    input  logic       btn_start,
    input  logic [3:0] exit_req,
    output logic       tile_req,
    output logic [5:0] tile_addr,
    input  logic       tile_ack,
    input  logic [3:0] tile_data,
    output logic [2:0] map_x,
    output logic [2:0] map_y,
    output logic [3:0] tile_code,
    output logic       move_en,
    output logic       respawn,
    output logic [3:0] spawn_side,
    output logic [2:0] fade_level,
    output logic [2:0] game_state
);

    localparam int unsigned COORD_W = 3;
    localparam logic [COORD_W-1:0] START_X3 = COORD_W'(START_X);
    localparam logic [COORD_W-1:0] START_Y3 = COORD_W'(START_Y);
    localparam logic [COORD_W-1:0] GOAL_X3  = COORD_W'(GOAL_X);
    localparam logic [COORD_W-1:0] GOAL_Y3  = COORD_W'(GOAL_Y);
    localparam logic [COORD_W-1:0] COORD_MAX = COORD_W'(7);
    localparam logic [3:0] SIDE_N = 4'b0001;
    localparam logic [3:0] SIDE_E = 4'b0010;
    localparam logic [3:0] SIDE_S = 4'b0100;
    localparam logic [3:0] SIDE_W = 4'b1000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_FADE_IN  = 3'd2,
        S_PLAY     = 3'd3,
        S_FADE_OUT = 3'd4,
        S_WIN      = 3'd5
    } state_t;

    state_t               state, nxt_state;
    logic [COORD_W-1:0]   nxt_map_x, nxt_map_y;
    logic [3:0]           nxt_tile_code, nxt_side;
    logic                 nxt_tile_req, nxt_respawn, nxt_move_en;
    logic                 btn_s1, btn_s2, btn_prev, btn_rise;
    logic                 exit_ok;
    logic [COORD_W-1:0]   exit_x, exit_y;
    logic [3:0]           exit_side;

    assign game_state = state;
    assign tile_addr  = {map_y, map_x};
    assign btn_rise   = btn_s2 & ~btn_prev;

`ifdef MEIKYUU_ROOM_FADE_EN
    localparam int unsigned FCNT_W = 4;
    localparam logic [FCNT_W-1:0] FCNT_LAST = FCNT_W'(FADE_FRAMES - 1);

    logic [FCNT_W-1:0]  frame_cnt, nxt_frame_cnt;
    logic [2:0]         fade_q, nxt_fade;
    logic [COORD_W-1:0] tgt_x, tgt_y, nxt_tgt_x, nxt_tgt_y;
    logic               frame_tick, tgt_goal;

    assign frame_tick = frame_start && (frame_cnt == FCNT_LAST);
    assign tgt_goal   = (tgt_x == GOAL_X3) && (tgt_y == GOAL_Y3);
    assign fade_level = fade_q;

    // Fade level, frame divider and latched exit target
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            fade_q    <= 3'd7;
            frame_cnt <= '0;
            tgt_x     <= START_X3;
            tgt_y     <= START_Y3;
        end else begin
            fade_q    <= nxt_fade;
            frame_cnt <= nxt_frame_cnt;
            tgt_x     <= nxt_tgt_x;
            tgt_y     <= nxt_tgt_y;
        end
    end
`else
    logic unused_fade;
    logic exit_goal;

    assign unused_fade = ^{frame_start, 4'(FADE_FRAMES)};
    assign exit_goal   = (exit_x == GOAL_X3) && (exit_y == GOAL_Y3);
    assign fade_level  = 3'd0;
`endif

    // Start button synchronizer plus edge-detect history
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            btn_s1   <= 1'b0;
            btn_s2   <= 1'b0;
            btn_prev <= 1'b0;
        end else begin
            btn_s1   <= btn_start;
            btn_s2   <= btn_s1;
            btn_prev <= btn_s2;
        end
    end

    // Highest-priority exit (N>E>S>W); an off-grid choice is dropped, not replaced
    always_comb begin
        exit_ok   = 1'b0;
        exit_x    = map_x;
        exit_y    = map_y;
        exit_side = spawn_side;
        if (exit_req[0]) begin
            exit_ok   = (map_y != '0);
            exit_y    = map_y - COORD_W'(1);
            exit_side = SIDE_S;
        end else if (exit_req[1]) begin
            exit_ok   = (map_x != COORD_MAX);
            exit_x    = map_x + COORD_W'(1);
            exit_side = SIDE_W;
        end else if (exit_req[2]) begin
            exit_ok   = (map_y != COORD_MAX);
            exit_y    = map_y + COORD_W'(1);
            exit_side = SIDE_N;
        end else if (exit_req[3]) begin
            exit_ok   = (map_x != '0);
            exit_x    = map_x - COORD_W'(1);
            exit_side = SIDE_E;
        end
    end

    // State and registered outputs
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state      <= S_IDLE;
            map_x      <= START_X3;
            map_y      <= START_Y3;
            tile_code  <= 4'd0;
            tile_req   <= 1'b0;
            respawn    <= 1'b0;
            move_en    <= 1'b0;
            spawn_side <= SIDE_S;
        end else begin
            state      <= nxt_state;
            map_x      <= nxt_map_x;
            map_y      <= nxt_map_y;
            tile_code  <= nxt_tile_code;
            tile_req   <= nxt_tile_req;
            respawn    <= nxt_respawn;
            move_en    <= nxt_move_en;
            spawn_side <= nxt_side;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        nxt_state     = state;
        nxt_map_x     = map_x;
        nxt_map_y     = map_y;
        nxt_tile_code = tile_code;
        nxt_side      = spawn_side;
        nxt_tile_req  = 1'b0;
        nxt_respawn   = 1'b0;
        nxt_move_en   = 1'b0;
`ifdef MEIKYUU_ROOM_FADE_EN
        nxt_fade      = fade_q;
        nxt_frame_cnt = frame_cnt;
        nxt_tgt_x     = tgt_x;
        nxt_tgt_y     = tgt_y;
`endif
        case (state)
            S_IDLE, S_WIN: begin
                if (btn_rise) begin
                    nxt_map_x    = START_X3;
                    nxt_map_y    = START_Y3;
                    nxt_side     = SIDE_S;
                    nxt_state    = S_LOAD;
                    nxt_tile_req = 1'b1;
                end
            end
            S_LOAD: begin
                if (tile_ack) begin
                    nxt_tile_code = tile_data;
`ifdef MEIKYUU_ROOM_FADE_EN
                    nxt_state     = S_FADE_IN;
                    nxt_fade      = 3'd7;
                    nxt_frame_cnt = '0;
`else
                    nxt_state     = S_PLAY;
                    nxt_respawn   = 1'b1;
                    nxt_move_en   = 1'b1;
`endif
                end else begin
                    nxt_tile_req = 1'b1;
                end
            end
`ifdef MEIKYUU_ROOM_FADE_EN
            S_FADE_IN: begin
                if (fade_q == 3'd0) begin
                    nxt_state   = S_PLAY;
                    nxt_respawn = 1'b1;
                    nxt_move_en = 1'b1;
                end else if (frame_start) begin
                    nxt_frame_cnt = frame_tick ? '0 : FCNT_W'(frame_cnt + 1'b1);
                    if (frame_tick) nxt_fade = fade_q - 3'd1;
                end
            end
`endif
            S_PLAY: begin
                nxt_move_en = 1'b1;
                if (exit_ok) begin
                    nxt_move_en = 1'b0;
                    nxt_side    = exit_side;
`ifdef MEIKYUU_ROOM_FADE_EN
                    nxt_tgt_x     = exit_x;
                    nxt_tgt_y     = exit_y;
                    nxt_state     = S_FADE_OUT;
                    nxt_fade      = 3'd0;
                    nxt_frame_cnt = '0;
`else
                    nxt_map_x = exit_x;
                    nxt_map_y = exit_y;
                    if (exit_goal) begin
                        nxt_state = S_WIN;
                    end else begin
                        nxt_state    = S_LOAD;
                        nxt_tile_req = 1'b1;
                    end
`endif
                end
            end
`ifdef MEIKYUU_ROOM_FADE_EN
            S_FADE_OUT: begin
                if (fade_q == 3'd7) begin
                    nxt_map_x = tgt_x;
                    nxt_map_y = tgt_y;
                    if (tgt_goal) begin
                        nxt_state = S_WIN;
                    end else begin
                        nxt_state    = S_LOAD;
                        nxt_tile_req = 1'b1;
                    end
                end else if (frame_start) begin
                    nxt_frame_cnt = frame_tick ? '0 : FCNT_W'(frame_cnt + 1'b1);
                    if (frame_tick) nxt_fade = fade_q + 3'd1;
                end
            end
`endif
            default: nxt_state = S_IDLE;
        endcase
    end

endmodule
